// File: rtl/tof_i2c_arbiter.sv
// tof_i2c_arbiter
//
// Round-robin scheduler that shares the single I2C master engine among the
// ToF sensor FSMs. A sensor asks for the bus by holding its req bit, receives
// an exclusive one-hot grant, and gives the bus back with a one-cycle done
// pulse. A grant is also withdrawn when the sensor drops its request, when
// its enable bit is cleared, or when it has held the bus for TIMEOUT_CYC
// cycles. After every release the bus stays idle for GUARD_CYC cycles before
// the next grant.
//
// Parameters
//   N_SENS       number of requesters
//   ID_W         width of a sensor index, clog2(N_SENS)
//   TIMEOUT_CYC  maximum grant length in clk cycles, 1..65535
//   GUARD_CYC    idle cycles between two grants, 0..255
//
// Ports
//   clk             system clock (clk_main domain)
//   rst             synchronous active-high reset
//   req             level request per sensor FSM
//   done            single-cycle release pulse per sensor FSM
//   enable_mask     1 = sensor may be granted (from ToF_CMD_in)
//   clr_status      pulse, clears timeout_sticky
//   grant           registered one-hot (or zero) bus grant
//   busy            high while a grant is active
//   active_id       index of the granted sensor, holds its value when idle
//   timeout_pulse   one-cycle pulse when a grant is revoked by timeout
//   timeout_sticky  per-sensor latched timeout flags (for ToF_CMD_out)

module tof_i2c_arbiter #(
  parameter int N_SENS      = 8,
  localparam int ID_W       = $clog2(N_SENS),
  parameter int TIMEOUT_CYC = 65535,
  parameter int GUARD_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] req,
  input  logic [N_SENS-1:0] done,
  input  logic [N_SENS-1:0] enable_mask,
  input  logic              clr_status,
  output logic [N_SENS-1:0] grant,
  output logic              busy,
  output logic [ID_W-1:0]   active_id,
  output logic              timeout_pulse,
  output logic [N_SENS-1:0] timeout_sticky
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  // The grant counter starts at 0 in the first granted cycle, so reaching
  // TIMEOUT_CYC-1 marks the last cycle the grant may be held.
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYC - 1);

  state_t              state;
  state_t              state_nxt;
  logic [N_SENS-1:0]   grant_nxt;
  logic [ID_W-1:0]     active_id_nxt;
  logic [ID_W-1:0]     last_id;
  logic [ID_W-1:0]     last_id_nxt;
  logic [15:0]         cnt;
  logic [15:0]         cnt_nxt;
  logic [7:0]          guard_cnt;
  logic [7:0]          guard_cnt_nxt;
  logic                timeout_pulse_nxt;
  logic [N_SENS-1:0]   timeout_set;
  logic [N_SENS-1:0]   sticky_nxt;

  logic [N_SENS-1:0]   eligible;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic                release_now;

  assign eligible = req & enable_mask;

  // Round-robin pick: search upward starting one past the last granted
  // sensor and wrap, so the most recently served sensor is considered last.
  // This is evaluated every cycle but only used in IDLE, which is what lets
  // an enable_mask change land in the same edge's arbitration.
  always_comb begin
    logic [ID_W-1:0] cand;
    pick_found = 1'b0;
    pick_id    = last_id;
    cand       = '0;
    for (int off = 1; off <= N_SENS; off++) begin
      cand = ID_W'((int'(last_id) + off) % N_SENS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state and next-output logic. Everything holds by default; only the
  // state being serviced changes the registers it owns. In GRANT the release
  // causes are checked in priority order: a done pulse from the owner is a
  // clean release, a withdrawn request or enable is a silent revoke, and
  // only when neither applies does the timeout count against the sensor.
  always_comb begin
    state_nxt         = state;
    grant_nxt         = grant;
    active_id_nxt     = active_id;
    last_id_nxt       = last_id;
    cnt_nxt           = cnt;
    guard_cnt_nxt     = guard_cnt;
    timeout_pulse_nxt = 1'b0;
    timeout_set       = '0;
    release_now       = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt     = N_SENS'(1) << pick_id;
          active_id_nxt = pick_id;
          last_id_nxt   = pick_id;
          cnt_nxt       = '0;
          state_nxt     = GRANT;
        end
      end

      GRANT: begin
        cnt_nxt = cnt + 16'd1;
        if (done[active_id]) begin
          release_now = 1'b1;
        end else if (!req[active_id] || !enable_mask[active_id]) begin
          release_now = 1'b1;
        end else if (cnt == TO_LAST) begin
          release_now       = 1'b1;
          timeout_pulse_nxt = 1'b1;
          timeout_set       = N_SENS'(1) << active_id;
        end

        if (release_now) begin
          grant_nxt = '0;
          if (GUARD_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt     = GUARD;
            guard_cnt_nxt = '0;
          end
        end
      end

      GUARD: begin
        guard_cnt_nxt = guard_cnt + 8'd1;
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase

    // A new timeout flag beats a simultaneous clear for that bit only.
    sticky_nxt = (clr_status ? '0 : timeout_sticky) | timeout_set;
  end

  // State and output registers. Reset leaves last_id at the top index so the
  // first search after reset begins at sensor 0, and it drops any grant in
  // progress without reporting a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      active_id      <= '0;
      last_id        <= ID_W'(N_SENS - 1);
      cnt            <= '0;
      guard_cnt      <= '0;
      timeout_pulse  <= 1'b0;
      timeout_sticky <= '0;
    end else begin
      state          <= state_nxt;
      grant          <= grant_nxt;
      active_id      <= active_id_nxt;
      last_id        <= last_id_nxt;
      cnt            <= cnt_nxt;
      guard_cnt      <= guard_cnt_nxt;
      timeout_pulse  <= timeout_pulse_nxt;
      timeout_sticky <= sticky_nxt;
    end
  end

  assign busy = (state == GRANT);

  // Structural invariants of the arbiter: the bus is never shared, busy
  // tracks the grant exactly, and a timeout pulse only follows a revoke.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant));
  a_busy_matches_grant : assert property (@(posedge clk) disable iff (rst)
    busy == (grant != '0));
  a_pulse_no_grant : assert property (@(posedge clk) disable iff (rst)
    timeout_pulse |-> (grant == '0));

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// tb_tof_i2c_arbiter
//
// Drives two arbiter builds: unit A (TIMEOUT_CYC=100, GUARD_CYC=4) for the
// main behaviour and unit B (TIMEOUT_CYC=100, GUARD_CYC=0) for back-to-back
// grants. The stimulus process queues the grant episodes and register
// snapshots it expects; one monitor process pops and compares them.

module tb_tof_i2c_arbiter;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] id;
    int         len;
    int         gap;
    logic       tmo;
  } exp_t;

  typedef struct {
    int         tag;
    logic [7:0] grant;
    logic       busy;
    logic [2:0] id;
    logic       tp;
    logic [7:0] sticky;
  } snap_t;

  logic       clk;
  logic       rst;
  logic [7:0] req_a, done_a, mask_a;
  logic       clr_a;
  logic [7:0] grant_a, sticky_a;
  logic       busy_a, tp_a;
  logic [2:0] id_a;
  logic [7:0] req_b, done_b, mask_b;
  logic       clr_b;
  logic [7:0] grant_b, sticky_b;
  logic       busy_b, tp_b;
  logic [2:0] id_b;

  exp_t  qa[$];
  exp_t  qb[$];
  snap_t snapq[$];

  int checks = 0;
  int errors = 0;
  bit endReq = 1'b0;

  // Monitor bookkeeping per unit.
  exp_t       cur[2];
  logic [7:0] prevG[2];
  int         runLen[2];
  int         gapLen[2];
  bit         tpLow[2];
  logic [7:0] g;
  logic [2:0] idv;
  logic       bz;
  logic       tpv;
  snap_t      s;
  bit         haveExp;

  tof_i2c_arbiter #(.N_SENS(8), .TIMEOUT_CYC(100), .GUARD_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req_a), .done(done_a), .enable_mask(mask_a),
    .clr_status(clr_a), .grant(grant_a), .busy(busy_a), .active_id(id_a),
    .timeout_pulse(tp_a), .timeout_sticky(sticky_a)
  );

  tof_i2c_arbiter #(.N_SENS(8), .TIMEOUT_CYC(100), .GUARD_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .done(done_b), .enable_mask(mask_b),
    .clr_status(clr_b), .grant(grant_b), .busy(busy_b), .active_id(id_b),
    .timeout_pulse(tp_b), .timeout_sticky(sticky_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the monitor calls this, so the counters have a single writer.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m);
    req_a  = r;
    mask_a = m;
  endtask

  task automatic pushA(input logic [7:0] gr, input logic [2:0] id,
                       input int len, input int gap, input logic tmo);
    exp_t e;
    e = '{gr, id, len, gap, tmo};
    qa.push_back(e);
  endtask

  task automatic pushB(input logic [7:0] gr, input logic [2:0] id,
                       input int len, input int gap);
    exp_t e;
    e = '{gr, id, len, gap, 1'b0};
    qb.push_back(e);
  endtask

  task automatic pushSnap(input int tag, input logic [7:0] gr, input logic bsy,
                          input logic [2:0] id, input logic tp,
                          input logic [7:0] st);
    snap_t e;
    e = '{tag, gr, bsy, id, tp, st};
    snapq.push_back(e);
  endtask

  // Bounded wait for a grant on the selected unit; returns at a negedge.
  task automatic waitGrant(input bit b);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if ((b ? grant_b : grant_a) != 8'h00) seen = 1'b1;
    end
    if (!seen) begin
      $display("[TB] FAIL waitGrant unit=%0d actual=no_grant required=grant_within_400", b);
      $fatal(1, "[TB] stopping: expected grant never arrived");
    end
  endtask

  // Hold the grant d more edges, then pulse done for sensor id (sampled on
  // the following edge), optionally dropping all requests with it.
  task automatic serve(input bit b, input int d, input logic [2:0] id,
                       input bit drop);
    repeat (d) @(posedge clk);
    #1;
    if (b) begin
      done_b = 8'b1 << id;
      if (drop) req_b = 8'h00;
    end else begin
      done_a = 8'b1 << id;
      if (drop) req_a = 8'h00;
    end
    @(posedge clk);
    #1;
    done_a = 8'h00;
    done_b = 8'h00;
  endtask

  // Stimulus: directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    req_a = 8'h00; done_a = 8'h00; mask_a = 8'hFF; clr_a = 1'b0;
    req_b = 8'h00; done_b = 8'h00; mask_b = 8'hFF; clr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushSnap(1, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
    rst = 1'b0;

    // Single requester, done release, guard gap of 4 + 1 idle cycle.
    @(posedge clk);
    #1;
    pushA(8'h04, 3'd2, 4, -1, 1'b0);
    pushA(8'h04, 3'd2, 4, 5, 1'b0);
    applyStimulus(8'h04, 8'hFF);
    pushSnap(2, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    pushSnap(3, 8'h04, 1'b1, 3'd2, 1'b0, 8'h00);
    serve(1'b0, 3, 3'd2, 1'b0);
    waitGrant(1'b0);
    serve(1'b0, 3, 3'd2, 1'b1);

    // All eight requesting: order 0..7 then 0 again.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 9; i++) pushA(8'b1 << (i % 8), 3'(i % 8), 4, (i == 0) ? -1 : 5, 1'b0);
    applyStimulus(8'hFF, 8'hFF);
    for (int i = 0; i < 9; i++) begin
      waitGrant(1'b0);
      serve(1'b0, 3, 3'(i % 8), i == 8);
    end

    // Timeout: grant held exactly 100 cycles, pulse, sticky flag.
    repeat (8) @(posedge clk);
    #1;
    pushA(8'h01, 3'd0, 100, -1, 1'b1);
    applyStimulus(8'h01, 8'hFF);
    waitGrant(1'b0);
    repeat (100) @(posedge clk);
    #1;
    applyStimulus(8'h00, 8'hFF);
    pushSnap(4, 8'h00, 1'b0, 3'd0, 1'b1, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    pushSnap(5, 8'h00, 1'b0, 3'd0, 1'b0, 8'h01);

    // done on the last allowed cycle wins over the timeout.
    repeat (2) @(posedge clk);
    #1;
    pushA(8'h01, 3'd0, 100, -1, 1'b0);
    applyStimulus(8'h01, 8'hFF);
    waitGrant(1'b0);
    serve(1'b0, 99, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    pushSnap(6, 8'h00, 1'b0, 3'd0, 1'b0, 8'h01);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    pushSnap(7, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);

    // Masked requester, enable withdrawn mid-grant, stray done[4] pulses.
    repeat (6) @(posedge clk);
    #1;
    pushA(8'h20, 3'd5, 4, -1, 1'b0);
    applyStimulus(8'h30, 8'hEF);
    waitGrant(1'b0);
    @(posedge clk); #1; done_a = 8'h10;
    @(posedge clk); #1; done_a = 8'h00;
    @(posedge clk); #1; applyStimulus(8'h30, 8'hCF);
    @(posedge clk); #1;
    pushSnap(8, 8'h00, 1'b0, 3'd5, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; done_a = 8'h10;
      @(posedge clk); #1; done_a = 8'h00;
    end
    applyStimulus(8'h00, 8'hFF);

    // Reset in the middle of a grant to sensor 3, all still requesting.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    pushA(8'h08, 3'd3, -1, -1, 1'b0);
    applyStimulus(8'h08, 8'hFF);
    waitGrant(1'b0);
    @(posedge clk);
    #1;
    applyStimulus(8'hFF, 8'hFF);
    rst = 1'b1;
    pushA(8'h01, 3'd0, 3, 1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushSnap(9, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
    waitGrant(1'b0);
    serve(1'b0, 2, 3'd0, 1'b1);

    // Zero-guard build: one idle cycle between consecutive grants.
    @(posedge clk);
    #1;
    pushB(8'h01, 3'd0, 3, -1);
    pushB(8'h02, 3'd1, 3, 1);
    pushB(8'h04, 3'd2, 3, 1);
    pushB(8'h08, 3'd3, 3, 1);
    req_b = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      waitGrant(1'b1);
      serve(1'b1, 2, 3'(i), i == 3);
    end

    repeat (10) @(posedge clk);
    endReq = 1'b1;
  end

  // Monitor: compares queued snapshots and grant episodes at each negedge.
  initial begin
    for (int u = 0; u < 2; u++) begin
      prevG[u]  = 8'h00;
      runLen[u] = 0;
      gapLen[u] = 0;
      tpLow[u]  = 1'b0;
      cur[u]    = '{8'h00, 3'd0, -1, -1, 1'b0};
    end
    forever begin
      @(negedge clk);
      if (snapq.size() > 0) begin
        s = snapq.pop_front();
        checkOutput($sformatf("snap%0d.grant", s.tag), 32'(grant_a), 32'(s.grant));
        checkOutput($sformatf("snap%0d.busy", s.tag), 32'(busy_a), 32'(s.busy));
        checkOutput($sformatf("snap%0d.active_id", s.tag), 32'(id_a), 32'(s.id));
        checkOutput($sformatf("snap%0d.timeout_pulse", s.tag), 32'(tp_a), 32'(s.tp));
        checkOutput($sformatf("snap%0d.timeout_sticky", s.tag), 32'(sticky_a), 32'(s.sticky));
      end
      for (int u = 0; u < 2; u++) begin
        g   = (u == 0) ? grant_a : grant_b;
        idv = (u == 0) ? id_a : id_b;
        bz  = (u == 0) ? busy_a : busy_b;
        tpv = (u == 0) ? tp_a : tp_b;
        if (tpLow[u]) begin
          checkOutput($sformatf("u%0d.pulse_width", u), 32'(tpv), 32'd0);
          tpLow[u] = 1'b0;
        end
        if (g != 8'h00 && prevG[u] == 8'h00) begin
          haveExp = (u == 0) ? (qa.size() > 0) : (qb.size() > 0);
          if (!haveExp) begin
            checks++;
            errors++;
            $display("[TB] FAIL u%0d.unexpected_grant actual=%0h required=none", u, g);
            cur[u] = '{g, idv, -1, -1, 1'b0};
          end else begin
            if (u == 0) cur[u] = qa.pop_front();
            else        cur[u] = qb.pop_front();
            checkOutput($sformatf("u%0d.grant", u), 32'(g), 32'(cur[u].grant));
            checkOutput($sformatf("u%0d.active_id", u), 32'(idv), 32'(cur[u].id));
            checkOutput($sformatf("u%0d.busy_on", u), 32'(bz), 32'd1);
            if (cur[u].gap >= 0)
              checkOutput($sformatf("u%0d.gap", u), 32'(gapLen[u]), 32'(cur[u].gap));
          end
          runLen[u] = 1;
        end else if (g != 8'h00) begin
          runLen[u]++;
          checkOutput($sformatf("u%0d.grant_stable", u), 32'(g), 32'(cur[u].grant));
          checkOutput($sformatf("u%0d.onehot", u), 32'($onehot(g)), 32'd1);
        end else if (prevG[u] != 8'h00) begin
          if (cur[u].len >= 0)
            checkOutput($sformatf("u%0d.grant_len", u), 32'(runLen[u]), 32'(cur[u].len));
          checkOutput($sformatf("u%0d.timeout_pulse", u), 32'(tpv), 32'(cur[u].tmo));
          checkOutput($sformatf("u%0d.busy_off", u), 32'(bz), 32'd0);
          tpLow[u]  = 1'b1;
          gapLen[u] = 1;
        end else begin
          gapLen[u]++;
        end
        prevG[u] = g;
      end
      if (endReq) begin
        checkOutput("qa_drained", 32'(qa.size()), 32'd0);
        checkOutput("qb_drained", 32'(qb.size()), 32'd0);
        checkOutput("snap_drained", 32'(snapq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tof_i2c_arbiter.md
# tof_i2c_arbiter

Round-robin scheduler sharing the single I2C master engine among the eight ToF sensor FSMs in `top`. Each sensor FSM requests the bus, receives an exclusive one-hot grant, and releases it with a `done` pulse. The arbiter enforces a per-grant timeout and a guard gap between grants. Requests are qualified by the sensor enable mask taken from the Zynq command register (`ToF_CMD_in`), and sticky per-sensor timeout flags are reported back for `ToF_CMD_out`.

## Interface
- `N_SENS`, 8: number of requesters; `ID_W` = clog2(`N_SENS`).
- `TIMEOUT_CYC`, 65535: maximum grant length in `clk` cycles, range 1..65535; counter is 16 bit.
- `GUARD_CYC`, 4: idle cycles with no grant between two grants, range 0..255.
- `clk` in 1: system clock (`clk_main` domain).
- `rst` in 1: synchronous, active-high reset.
- `req` in `N_SENS`: level request per sensor FSM.
- `done` in `N_SENS`: single-cycle release pulse per sensor FSM.
- `enable_mask` in `N_SENS`: 1 = sensor may be granted (from `ToF_CMD_in`).
- `clr_status` in 1: pulse; clears `timeout_sticky`.
- `grant` out `N_SENS`: one-hot or zero; registered.
- `busy` out 1: high while in GRANT.
- `active_id` out `ID_W`: index of the granted sensor; holds last value outside GRANT.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked by timeout.
- `timeout_sticky` out `N_SENS`: per-sensor latched timeout flags.

## Operation
- States: IDLE, GRANT, GUARD.
- `eligible = req & enable_mask`.
- IDLE: if `eligible` is nonzero, pick the first set bit searching upward from `(last_id+1) mod N_SENS` with wrap. Load `grant`, `active_id`, and `last_id`, zero the counter, and go to GRANT. Otherwise stay in IDLE.
- GRANT: the counter increments every cycle. Release conditions are checked in this priority order:
  1. `done[active_id]` = 1 -> release.
  2. `req[active_id]` = 0 or `enable_mask[active_id]` = 0 -> revoke without a timeout flag.
  3. Counter = `TIMEOUT_CYC-1` -> revoke, pulse `timeout_pulse`, set `timeout_sticky[active_id]`.
- On any release, clear `grant` and go to GUARD. If `GUARD_CYC` = 0, go directly to IDLE.
- `done` bits of non-granted sensors are ignored.
- GUARD: count `GUARD_CYC` cycles with `grant` = 0, then go to IDLE.
- `timeout_sticky`: a set on the same cycle as `clr_status` wins for that bit; all other bits clear.
- Round-robin fairness: with all eight requesting continuously, each sensor is granted exactly once per 8 grants.

## Timing
- Reset values: state IDLE, `grant` = 0, `busy` = 0, `active_id` = 0, `last_id` = `N_SENS-1` (first search starts at 0), counter = 0, `timeout_pulse` = 0, `timeout_sticky` = 0.
- Grant latency: `eligible` sampled high at edge k -> `grant` and `busy` high after edge k.
- Release: condition sampled at edge k -> `grant` = 0 after edge k. The next grant appears no earlier than edge k+`GUARD_CYC`+1.
- Timeout: `grant` is high for exactly `TIMEOUT_CYC` cycles. `timeout_pulse` is high in the cycle following the last granted cycle.
- Grant is never asserted to two sensors at once, and never for zero cycles.
- `rst` asserted mid-grant: all outputs return to reset values on that edge. No `timeout_pulse` is generated.
- `enable_mask` changes in IDLE take effect at the same edge's arbitration.

## Test plan
- Reset, then `req`=8'h04, `enable_mask`=8'hFF -> `grant`=8'h04 one cycle after the request is sampled, `active_id`=2. `done[2]` pulse -> `grant`=0 on the next edge, then 4 guard cycles with no grant.
- `req`=8'hFF held, `done` pulsed each grant after 3 cycles -> grant order 0,1,...,7,0. Each sensor is granted once per 8 grants; `grant` is always one-hot.
- `TIMEOUT_CYC`=100, `req`=8'h01 held, no `done` -> `grant[0]` high exactly 100 cycles, `timeout_pulse` high for 1 cycle, `timeout_sticky`=8'h01. `clr_status` -> `timeout_sticky`=8'h00.
- `done[active]` on the same cycle the counter reaches `TIMEOUT_CYC-1` -> normal release, `timeout_pulse` stays 0, sticky unchanged.
- `req`=8'h30 with `enable_mask`=8'hEF -> only sensor 5 is granted. While granted, clear `enable_mask[5]` -> revoke on the next edge with no timeout flag. `done[4]` pulses are ignored throughout.
- `rst` asserted for 1 cycle while `grant`=8'h08 -> all outputs at reset values after that edge. With `req`=8'hFF still held, the first grant after reset is sensor 0. `GUARD_CYC`=0 build: back-to-back grants separated by a single IDLE cycle.
